// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register with stall, flush and a saturating bubble counter.
// Every output comes straight from a flop. A bubble (flush, or a load of an invalid slot) bumps the counter on that same edge.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EnE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  ALUsrcD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic [3:0]            ALUControlD,
    input  logic [2:0]            Funct3D,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic [4:0]            RdD,
    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  ALUsrcE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic [3:0]            ALUControlE,
    output logic [2:0]            Funct3E,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic [4:0]            RdE,
    output logic [CNT_WIDTH-1:0]  BubbleCount
);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  alu_src;
        logic                  branch;
        logic                  jump;
        logic [3:0]            alu_control;
        logic [2:0]            funct3;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
    } ex_bundle_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    ex_bundle_t           ex_d, ex_q;
    logic [CNT_WIDTH-1:0] bubble_cnt_d, bubble_cnt_q;
    logic                 bubble_s;

    // Next-state of the execute bundle and the bubble counter.
    always_comb begin
        ex_d         = ex_q;
        bubble_s     = 1'b0;
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE) begin
            ex_d     = '0;
            bubble_s = 1'b1;
        end else if (EnE) begin
            ex_d.valid       = ValidD;
            ex_d.result_src  = ResultSrcD;
            ex_d.alu_src     = ALUsrcD;
            ex_d.alu_control = ALUControlD;
            ex_d.funct3      = Funct3D;
            ex_d.rd1         = RD1D;
            ex_d.rd2         = RD2D;
            ex_d.pc          = PCD;
            ex_d.pc_plus4    = PCPlus4D;
            ex_d.imm_ext     = ImmExtD;
            ex_d.rs1         = Rs1D;
            ex_d.rs2         = Rs2D;
            ex_d.rd          = RdD;
            // Select rather than AND so unknown controls on an invalid slot still yield a clean 0.
            if (ValidD) begin
                ex_d.reg_write = RegWriteD;
                ex_d.mem_write = MemWriteD;
                ex_d.branch    = BranchD;
                ex_d.jump      = JumpD;
            end else begin
                ex_d.valid     = 1'b0;
                ex_d.reg_write = 1'b0;
                ex_d.mem_write = 1'b0;
                ex_d.branch    = 1'b0;
                ex_d.jump      = 1'b0;
                bubble_s       = 1'b1;
            end
        end else begin
            ex_d = ex_q;
        end

        if (bubble_s && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ValidE      = ex_q.valid;
    assign RegWriteE   = ex_q.reg_write;
    assign ResultSrcE  = ex_q.result_src;
    assign MemWriteE   = ex_q.mem_write;
    assign ALUsrcE     = ex_q.alu_src;
    assign BranchE     = ex_q.branch;
    assign JumpE       = ex_q.jump;
    assign ALUControlE = ex_q.alu_control;
    assign Funct3E     = ex_q.funct3;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign ImmExtE     = ex_q.imm_ext;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign BubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a default-width instance plus a 4-bit-counter instance
// on the same stimulus; expected outputs are queued per edge and checked by an independent monitor.
module tb_id_ex_pipeline_reg;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, EnE, FlushE, ValidD, RegWriteD, MemWriteD, ALUsrcD, BranchD, JumpD;
    logic [1:0]    ResultSrcD;
    logic [3:0]    ALUControlD;
    logic [2:0]    Funct3D;
    logic [DW-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]    Rs1D, Rs2D, RdD;

    logic          ValidE, RegWriteE, MemWriteE, ALUsrcE, BranchE, JumpE;
    logic [1:0]    ResultSrcE;
    logic [3:0]    ALUControlE;
    logic [2:0]    Funct3E;
    logic [DW-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]    Rs1E, Rs2E, RdE;
    logic [15:0]   BubbleCount;

    logic          s_ValidE, s_RegWriteE, s_MemWriteE, s_ALUsrcE, s_BranchE, s_JumpE;
    logic [1:0]    s_ResultSrcE;
    logic [3:0]    s_ALUControlE;
    logic [2:0]    s_Funct3E;
    logic [DW-1:0] s_RD1E, s_RD2E, s_PCE, s_PCPlus4E, s_ImmExtE;
    logic [4:0]    s_Rs1E, s_Rs2E, s_RdE;
    logic [3:0]    s_BubbleCount;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .EnE(EnE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .ALUsrcD(ALUsrcD),
        .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD), .Funct3D(Funct3D),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .ALUsrcE(ALUsrcE), .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE),
        .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BubbleCount(BubbleCount)
    );

    id_ex_pipeline_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .EnE(EnE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .ALUsrcD(ALUsrcD),
        .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD), .Funct3D(Funct3D),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(s_ValidE), .RegWriteE(s_RegWriteE), .ResultSrcE(s_ResultSrcE),
        .MemWriteE(s_MemWriteE), .ALUsrcE(s_ALUsrcE), .BranchE(s_BranchE), .JumpE(s_JumpE),
        .ALUControlE(s_ALUControlE), .Funct3E(s_Funct3E), .RD1E(s_RD1E), .RD2E(s_RD2E),
        .PCE(s_PCE), .PCPlus4E(s_PCPlus4E), .ImmExtE(s_ImmExtE), .Rs1E(s_Rs1E),
        .Rs2E(s_Rs2E), .RdE(s_RdE), .BubbleCount(s_BubbleCount)
    );

    // Expected execute-stage view in port order.
    typedef struct packed {
        logic valid, reg_write;
        logic [1:0] result_src;
        logic mem_write, alu_src, branch, jump;
        logic [3:0] alu_control;
        logic [2:0] funct3;
        logic [DW-1:0] rd1, rd2, pc, pc_plus4, imm_ext;
        logic [4:0] rs1, rs2, rd;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } entry_t;

    entry_t scoreboard[$];
    exp_t   model_e;
    int     model_c16, model_c4;
    int     compared   = 0;
    int     mismatched = 0;

    wire exp_t act_e = '{ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUsrcE, BranchE, JumpE,
                         ALUControlE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};
    wire exp_t act_s = '{s_ValidE, s_RegWriteE, s_ResultSrcE, s_MemWriteE, s_ALUsrcE, s_BranchE,
                         s_JumpE, s_ALUControlE, s_Funct3E, s_RD1E, s_RD2E, s_PCE, s_PCPlus4E,
                         s_ImmExtE, s_Rs1E, s_Rs2E, s_RdE};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new output every edge; compare it against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() > 0) begin
                entry_t x;
                x = scoreboard.pop_front();
                check("e_bundle",     256'(act_e),         256'(x.e));
                check("e_bundle_w4",  256'(act_s),         256'(x.e));
                check("bubble_cnt16", 256'(BubbleCount),   256'(x.cnt16));
                check("bubble_cnt4",  256'(s_BubbleCount), 256'(x.cnt4));
            end
        end
    end

    task automatic randomize_d(input logic valid);
        ValidD      = valid;
        RegWriteD   = 1'($urandom);
        ResultSrcD  = 2'($urandom);
        MemWriteD   = 1'($urandom);
        ALUsrcD     = 1'($urandom);
        BranchD     = 1'($urandom);
        JumpD       = 1'($urandom);
        ALUControlD = 4'($urandom);
        Funct3D     = 3'($urandom);
        RD1D        = $urandom;
        RD2D        = $urandom;
        PCD         = $urandom;
        PCPlus4D    = PCD + 32'd4;
        ImmExtD     = $urandom;
        Rs1D        = 5'($urandom);
        Rs2D        = 5'($urandom);
        RdD         = 5'($urandom);
    endtask

    // Apply controls at a falling edge, predict the next rising edge from the behavioural rules, queue it.
    task automatic cycle(input logic r, input logic en, input logic fl);
        entry_t x;
        rst_n  = r;
        EnE    = en;
        FlushE = fl;
        if (!r) begin
            model_e   = '0;
            model_c16 = 0;
            model_c4  = 0;
        end else if (fl || (en && !ValidD)) begin
            if (fl) model_e = '0;
            else model_e = '{1'b0, 1'b0, ResultSrcD, 1'b0, ALUsrcD, 1'b0, 1'b0, ALUControlD, Funct3D,
                             RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
            model_c16 = (model_c16 + 1 > 65535) ? 65535 : model_c16 + 1;
            model_c4  = (model_c4 + 1 > 15) ? 15 : model_c4 + 1;
        end else if (en) begin
            model_e = '{1'b1, RegWriteD, ResultSrcD, MemWriteD, ALUsrcD, BranchD, JumpD, ALUControlD,
                        Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
        end
        x.e     = model_e;
        x.cnt16 = 16'(model_c16);
        x.cnt4  = 4'(model_c4);
        scoreboard.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        model_e   = '0;
        model_c16 = 0;
        model_c4  = 0;
        randomize_d(1'b1);
        @(negedge clk);

        // Reset for two edges, then a directed load.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        randomize_d(1'b1);
        RegWriteD = 1'b1; RdD = 5'd5; RD1D = 32'h0000_00AA; PCD = 32'h0000_0100;
        cycle(1'b1, 1'b1, 1'b0);
        check("load_rd1", 256'(RD1E), 256'(32'h0000_00AA));

        // Stall: A loads, B waits on the inputs for three edges.
        randomize_d(1'b1); RdD = 5'd3;
        cycle(1'b1, 1'b1, 1'b0);
        randomize_d(1'b1); RdD = 5'd7;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        check("stall_rd", 256'(RdE), 256'(5'd3));
        cycle(1'b1, 1'b1, 1'b0);

        // Flush beats stall while E holds store + jump.
        randomize_d(1'b1); MemWriteD = 1'b1; JumpD = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);

        // Invalid slot with all write/redirect controls raised.
        randomize_d(1'b0);
        RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b1; RD2D = 32'h0000_1234;
        cycle(1'b1, 1'b1, 1'b0);

        // Saturation of the 4-bit counter, then reset clears it.
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            randomize_d(1'($urandom));
            cycle(1'b1, 1'($urandom), 1'b1);
        end
        check("sat_w4", 256'(s_BubbleCount), 256'(4'd15));
        cycle(1'b0, 1'b0, 1'b0);

        // Reset coincident with flush and a valid load.
        randomize_d(1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        randomize_d(1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("rst_mid_cnt", 256'(BubbleCount), 256'(16'd0));

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            randomize_d(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            cycle(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        compared++;
        if (scoreboard.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
